// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the MiniAlu core.
//
// Owns the program counter, drives the instruction ROM address, and
// registers the fetched word toward decode. JMP is resolved here and never
// reaches decode. A NOP with a non-zero wait field is issued once and is
// then followed by exactly that many bubble cycles. Taken branches from
// execute redirect the PC and raise a one-cycle flush pulse.
//
// Ports:
//   Clock          system clock, rising edge
//   Reset          asynchronous, active-high reset
//   oAddress       ROM address, equal to the current PC
//   iInstruction   ROM data for oAddress (combinational, same cycle)
//   iStall         downstream cannot accept; freeze fetch
//   iBranchTaken   execute resolved a taken branch this cycle
//   iBranchTarget  branch target, zero-extended to ADDR_W
//   oInstruction   registered instruction to decode
//   oValid         oInstruction is a real instruction (0 = bubble)
//   oFlush         one-cycle pulse: squash the younger in-flight instruction
//   oWaiting       high while idling after a timed NOP
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | fetching one word per cycle from the PC
// ST_WAIT  | idling after a timed NOP; counter holds bubbles still owed

module fetch_sequencer #(
  parameter int         ADDR_W  = 16,
  parameter int         INSTR_W = 28,
  parameter logic [3:0] OP_NOP  = 4'd0,
  parameter logic [3:0] OP_JMP  = 4'd9,
  parameter int         WAIT_W  = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [7:0]         iBranchTarget,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oValid,
  output logic               oFlush,
  output logic               oWaiting
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               flush_q, flush_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]         opcode;
  logic [WAIT_W-1:0]  wait_field;
  logic [ADDR_W-1:0]  jmp_target;

  assign opcode     = iInstruction[INSTR_W-1 -: 4];
  assign wait_field = iInstruction[WAIT_W-1:0];
  assign jmp_target = ADDR_W'(iInstruction[23:16]);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;

    if (iBranchTaken) begin
      // A redirect wins over stall, a pending wait and a fetched JMP.
      pc_d    = ADDR_W'(iBranchTarget);
      instr_d = '0;
      valid_d = 1'b0;
      flush_d = 1'b1;
      cnt_d   = '0;
      state_d = ST_FETCH;
    end else if (iStall) begin
      // Everything holds; a stall inside WAIT stretches the wait.
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (opcode == OP_JMP) begin
            pc_d    = jmp_target;
            instr_d = '0;
            valid_d = 1'b0;
          end else begin
            instr_d = iInstruction;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            if (opcode == OP_NOP && wait_field != '0) begin
              cnt_d   = wait_field;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          instr_d = '0;
          valid_d = 1'b0;
          // A zero count cannot occur here, but leaving on it avoids a
          // 2^WAIT_W cycle lockup if the counter were ever corrupted.
          if (cnt_q == WAIT_W'(1) || cnt_q == '0) begin
            cnt_d   = '0;
            state_d = ST_FETCH;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = instr_q;
  assign oValid       = valid_q;
  assign oFlush       = flush_q;
  assign oWaiting     = (state_q == ST_WAIT);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the MiniAlu core.
- Owns the program counter and drives the instruction ROM address.
- Registers the returned 28-bit instruction toward decode, resolves JMP locally, and applies branch redirects coming back from execute.
- Implements the timed NOP (non-zero immediate = idle cycles) and pipeline stall/flush sequencing.

Parameters:
- ADDR_W, 16, ROM address / PC width
- INSTR_W, 28, instruction width; opcode in [INSTR_W-1:INSTR_W-4]
- OP_NOP, 4'd0, NOP opcode encoding
- OP_JMP, 4'd?, JMP opcode encoding; set from the shared opcode definitions at instantiation
- WAIT_W, 16, width of NOP wait count, taken from instruction bits [WAIT_W-1:0]

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- oAddress  output  ADDR_W  ROM address; equals the current PC (combinational from the PC register)
- iInstruction  input  INSTR_W  ROM data for oAddress; combinational, same cycle
- iStall  input  1  decode/execute cannot accept; freeze fetch
- iBranchTaken  input  1  execute resolved a taken BLE this cycle
- iBranchTarget  input  8  branch target, zero-extended to ADDR_W
- oInstruction  output  INSTR_W  registered instruction to decode
- oValid  output  1  oInstruction is a real instruction (0 = bubble)
- oFlush  output  1  one-cycle pulse: squash the younger in-flight instruction
- oWaiting  output  1  high while in WAIT state

Behaviour:
- Reset (async, any time, including mid-WAIT):
  - PC=0, oInstruction=0, oValid=0, oFlush=0, wait counter=0, state=FETCH.
  - First valid instruction appears on oInstruction one cycle after Reset deasserts (address 0).
- States: FETCH, WAIT.
- Priority per clock edge: Reset > iBranchTaken > iStall > JMP / timed-NOP decode > sequential fetch.
- iBranchTaken (either state, regardless of iStall):
  - PC<=zero-extended iBranchTarget.
  - oValid<=0, oInstruction<=0, oFlush<=1 for exactly one cycle.
  - Wait counter<=0, state<=FETCH.
  - Target instruction is valid on the following cycle. Branch penalty is 1 bubble.
- iStall (no branch): PC, oInstruction, oValid, state and wait counter all hold; oFlush<=0.
- FETCH, opcode==OP_JMP:
  - PC<=zero-extended iInstruction[23:16].
  - oValid<=0, oInstruction<=0. JMP never reaches decode; 1 bubble.
- FETCH, opcode==OP_NOP with wait field W=iInstruction[WAIT_W-1:0] != 0:
  - Issue the NOP (oValid<=1, oInstruction<=iInstruction).
  - PC<=PC+1, counter<=W, state<=WAIT.
- FETCH, otherwise (including NOP with W==0):
  - oInstruction<=iInstruction, oValid<=1, PC<=PC+1.
- WAIT:
  - oValid<=0, oInstruction<=0, PC holds, counter<=counter-1.
  - When counter==1 at the edge: counter<=0, state<=FETCH.
  - Exactly W bubble cycles follow the NOP. oWaiting=1 throughout WAIT.
- PC arithmetic: modulo 2^ADDR_W; 16'hFFFF+1 wraps to 0 with no flag.
- oFlush is high only in the cycle after a taken branch; otherwise 0.
- Simultaneous events:
  - Branch during WAIT aborts the wait.
  - Branch while the fetched word is JMP: branch wins, JMP discarded.
  - Stall during WAIT freezes the counter, so the wait is extended by the stall length.

Test Plan:
- Reset release with ROM[0..2] = ADD/ADD/ADD and no stall -> oAddress 0,1,2 on consecutive cycles; oValid=1 from cycle 1; oInstruction tracks ROM one cycle later.
- ROM[3] = JMP to 8'd2 -> oAddress sequence ...,3,2,3,2; oValid=0 in the cycle after each JMP fetch; the JMP word never appears on oInstruction.
- ROM[1] = NOP with imm 4 -> NOP valid once, then oValid=0 and oWaiting=1 for exactly 4 cycles, then ROM[2] valid; PC holds 2 throughout the wait.
- iBranchTaken=1, iBranchTarget=8'd5 asserted while iStall=1 and in WAIT -> next cycle oFlush=1, oValid=0, oWaiting=0, oAddress=5; ROM[5] valid the cycle after.
- iStall held 3 cycles mid-stream -> oAddress, oInstruction, oValid unchanged for 3 cycles; sequence resumes with no skipped or duplicated address.
- PC preset to 16'hFFFF via branch-free run (or forced) -> next address 16'h0000; Reset asserted mid-WAIT -> immediate oValid=0, oWaiting=0, oAddress=0.
